// File: rtl/mem_bus_pkg.sv
// Shared encodings for the byte-serial memory bus initiator:
// bus size codes, RISC-V load/store funct3 codes, FSM states and owner tags.
package mem_bus_pkg;

  localparam logic [2:0] BHW_BYTE = 3'b001;
  localparam logic [2:0] BHW_HALF = 3'b010;
  localparam logic [2:0] BHW_WORD = 3'b100;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Size code 11 has no RISC-V meaning here and falls back to a full word.
  function automatic logic [2:0] f3_to_bhw(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return BHW_BYTE;
      2'b01:   return BHW_HALF;
      default: return BHW_WORD;
    endcase
  endfunction

  function automatic logic [31:0] mask_store(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {24'b0, wd[7:0]};
      2'b01:   return {16'b0, wd[15:0]};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of a raw little-endian load word according to funct3.
// Bytes above the access size are ignored; also reused by core writeback.
module load_extend
  import mem_bus_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_raw,
  output logic [31:0] o_ext
);

  always_comb begin
    o_ext = i_raw;
    case (i_funct3)
      F3_B:    o_ext = {{24{i_raw[7]}}, i_raw[7:0]};
      F3_BU:   o_ext = {24'b0, i_raw[7:0]};
      F3_H:    o_ext = {{16{i_raw[15]}}, i_raw[15:0]};
      F3_HU:   o_ext = {16'b0, i_raw[15:0]};
      F3_W:    o_ext = i_raw;
      default: o_ext = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_bus_initiator.sv
// CPU-side single initiator of the byte-serial memory bus: arbitrates fetch and
// load/store requests (data first), issues one transaction, returns the result.
module mem_bus_initiator
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_ready,
  output logic [31:0] o_if_data,
  output logic        o_if_valid,
  input  logic        i_ls_req,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [2:0]  i_ls_funct3,
  input  logic        i_ls_write,
  output logic        o_ls_ready,
  output logic [31:0] o_ls_data,
  output logic        o_ls_valid,
  output logic        o_ls_error,
  output logic [31:0] o_bus_data,
  output logic [31:0] o_bus_address,
  output logic        o_bus_DV,
  output logic [2:0]  o_bhw,
  output logic        o_write_notread,
  input  logic [31:0] i_bus_data,
  input  logic        i_bus_DV,
  output logic        o_busy
);

  state_t          r_state;
  state_t          w_next;
  owner_t          r_owner;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic [2:0]      r_funct3;
  logic [2:0]      r_bhw;
  logic            r_write;
  logic            r_err;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_timeout;
  logic [31:0]     w_ext;

  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES));

  load_extend u_load_extend (
    .i_funct3 (r_funct3),
    .i_raw    (i_bus_data),
    .o_ext    (w_ext)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_ls_req || i_if_req) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (i_bus_DV || w_timeout) w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ls_ready = 1'b0;
    o_if_ready = 1'b0;
    o_bus_DV   = 1'b0;
    o_ls_valid = 1'b0;
    o_ls_data  = '0;
    o_if_valid = 1'b0;
    o_if_data  = '0;
    o_ls_error = 1'b0;
    o_busy     = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        o_ls_ready = i_ls_req;
        o_if_ready = i_if_req & ~i_ls_req;
      end
      ST_ISSUE: o_bus_DV = 1'b1;
      ST_RESP: begin
        o_ls_error = r_err;
        if (r_owner == OWN_LS) begin
          o_ls_valid = 1'b1;
          o_ls_data  = r_rdata;
        end else begin
          o_if_valid = 1'b1;
          o_if_data  = r_rdata;
        end
      end
      default: ;
    endcase
  end

  assign o_bus_address   = r_addr;
  assign o_bus_data      = r_wdata;
  assign o_bhw           = r_bhw;
  assign o_write_notread = r_write;

  // Request fields are latched on acceptance and held until the next one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner  <= OWN_IF;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_funct3 <= '0;
      r_bhw    <= '0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      if (o_ls_ready) begin
        r_owner  <= OWN_LS;
        r_addr   <= i_ls_addr;
        r_funct3 <= i_ls_funct3;
        r_bhw    <= f3_to_bhw(i_ls_funct3);
        r_write  <= i_ls_write;
        r_wdata  <= i_ls_write ? mask_store(i_ls_funct3, i_ls_wdata) : '0;
        r_err    <= 1'b0;
      end else if (o_if_ready) begin
        r_owner  <= OWN_IF;
        r_addr   <= i_if_addr;
        r_funct3 <= F3_W;
        r_bhw    <= BHW_WORD;
        r_write  <= 1'b0;
        r_wdata  <= '0;
        r_err    <= 1'b0;
      end
      if (r_state == ST_WAIT) begin
        if (i_bus_DV) begin
          if (r_owner == OWN_LS) r_rdata <= r_write ? '0 : w_ext;
          else                   r_rdata <= i_bus_data;
        end else if (w_timeout) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
      end
      r_to_cnt <= (r_state == ST_WAIT) ? r_to_cnt + TO_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Directed bench for mem_bus_initiator with a response scoreboard.
module tb_mem_bus_initiator;
  import mem_bus_pkg::*;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_ready;
  logic [31:0] o_if_data;
  logic        o_if_valid;
  logic        i_ls_req;
  logic [31:0] i_ls_addr;
  logic [31:0] i_ls_wdata;
  logic [2:0]  i_ls_funct3;
  logic        i_ls_write;
  logic        o_ls_ready;
  logic [31:0] o_ls_data;
  logic        o_ls_valid;
  logic        o_ls_error;
  logic [31:0] o_bus_data;
  logic [31:0] o_bus_address;
  logic        o_bus_DV;
  logic [2:0]  o_bhw;
  logic        o_write_notread;
  logic [31:0] i_bus_data;
  logic        i_bus_DV;
  logic        o_busy;

  always #5 clk = ~clk;

  mem_bus_initiator #(.TIMEOUT_CYCLES(TO), .TO_W(6)) dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_if_req        (i_if_req),
    .i_if_addr       (i_if_addr),
    .o_if_ready      (o_if_ready),
    .o_if_data       (o_if_data),
    .o_if_valid      (o_if_valid),
    .i_ls_req        (i_ls_req),
    .i_ls_addr       (i_ls_addr),
    .i_ls_wdata      (i_ls_wdata),
    .i_ls_funct3     (i_ls_funct3),
    .i_ls_write      (i_ls_write),
    .o_ls_ready      (o_ls_ready),
    .o_ls_data       (o_ls_data),
    .o_ls_valid      (o_ls_valid),
    .o_ls_error      (o_ls_error),
    .o_bus_data      (o_bus_data),
    .o_bus_address   (o_bus_address),
    .o_bus_DV        (o_bus_DV),
    .o_bhw           (o_bhw),
    .o_write_notread (o_write_notread),
    .i_bus_data      (i_bus_data),
    .i_bus_DV        (i_bus_DV),
    .o_busy          (o_busy)
  );

  typedef struct {
    logic        ls;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_rsp(input logic ls, input logic [31:0] d, input logic e);
    exp_t x;
    x.ls   = ls;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({o_if_ready, o_if_valid, o_ls_ready, o_ls_valid, o_ls_error,
                            o_bus_DV, o_bhw, o_write_notread, o_busy}), 32'd0);
    chk({tag, "_data"}, o_if_data | o_ls_data | o_bus_data | o_bus_address, 32'd0);
  endtask

  // Drive one request, wait for acceptance, then check the strobed bus fields.
  task automatic issue(input logic ls, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, input logic wr,
                       input logic [2:0] exp_bhw, input logic [31:0] exp_bdata);
    int n;
    @(posedge clk); #1;
    if (ls) begin
      i_ls_req = 1'b1; i_ls_addr = addr; i_ls_wdata = wd; i_ls_funct3 = f3; i_ls_write = wr;
    end else begin
      i_if_req = 1'b1; i_if_addr = addr;
    end
    n = 0;
    @(negedge clk);
    while (!(o_ls_ready || o_if_ready) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready", 32'(ls ? o_ls_ready : o_if_ready), 32'd1);
    @(posedge clk); #1;
    i_ls_req = 1'b0; i_if_req = 1'b0;
    i_ls_addr = $urandom; i_if_addr = $urandom; i_ls_wdata = $urandom;
    @(negedge clk);
    chk("bus_dv", 32'(o_bus_DV), 32'd1);
    chk("bus_addr", o_bus_address, addr);
    chk("bus_bhw", 32'(o_bhw), 32'(exp_bhw));
    chk("bus_write", 32'(o_write_notread), 32'(ls & wr));
    chk("bus_wdata", o_bus_data, exp_bdata);
  endtask

  // Memory answers 'delay' cycles after the strobe; valid must follow one cycle later.
  task automatic respond(input logic [31:0] d, input int delay);
    repeat (delay) @(posedge clk);
    #1;
    chk("strobe_one_cycle", 32'(o_bus_DV), 32'd0);
    i_bus_DV = 1'b1; i_bus_data = d;
    @(posedge clk); #1;
    i_bus_DV = 1'b0; i_bus_data = $urandom;
    @(negedge clk);
    chk("valid_latency", 32'(o_if_valid | o_ls_valid), 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (o_if_valid || o_ls_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", {30'b0, o_if_valid, o_ls_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_ls_valid", 32'(o_ls_valid), 32'(e.ls));
        chk("sb_if_valid", 32'(o_if_valid), 32'(!e.ls));
        chk("sb_data", e.ls ? o_ls_data : o_if_data, e.data);
        chk("sb_err", 32'(o_ls_error), 32'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    i_rst = 1'b1; i_if_req = 1'b0; i_if_addr = '0; i_ls_req = 1'b0; i_ls_addr = '0;
    i_ls_wdata = '0; i_ls_funct3 = '0; i_ls_write = 1'b0; i_bus_data = '0; i_bus_DV = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 i_rst = 1'b0;

    // Fetch, memory answers after 5 cycles
    issue(1'b0, 32'h0000_0010, 32'h0, 3'b000, 1'b0, BHW_WORD, 32'h0);
    expect_rsp(1'b0, 32'hDEAD_BEEF, 1'b0);
    respond(32'hDEAD_BEEF, 5);

    // Byte / half loads, signed and unsigned, with junk upper bytes
    issue(1'b1, 32'h0000_0003, 32'hFFFF_FFFF, F3_B, 1'b0, BHW_BYTE, 32'h0);
    expect_rsp(1'b1, 32'hFFFF_FF80, 1'b0);
    respond(32'h1234_5680, 2);
    issue(1'b1, 32'h0000_0003, 32'h0, F3_BU, 1'b0, BHW_BYTE, 32'h0);
    expect_rsp(1'b1, 32'h0000_0080, 1'b0);
    respond(32'h1234_5680, 1);
    issue(1'b1, 32'h0000_0102, 32'h0, F3_H, 1'b0, BHW_HALF, 32'h0);
    expect_rsp(1'b1, 32'hFFFF_8001, 1'b0);
    respond(32'hAAAA_8001, 3);
    issue(1'b1, 32'h0000_0102, 32'h0, F3_HU, 1'b0, BHW_HALF, 32'h0);
    expect_rsp(1'b1, 32'h0000_8001, 1'b0);
    respond(32'hAAAA_8001, 1);
    issue(1'b1, 32'h0000_0008, 32'h0, F3_W, 1'b0, BHW_WORD, 32'h0);
    expect_rsp(1'b1, 32'h8765_4321, 1'b0);
    respond(32'h8765_4321, 1);

    // Stores: data masked to size, completion returns 0
    issue(1'b1, 32'h0000_0100, 32'hCAFE_1234, F3_H, 1'b1, BHW_HALF, 32'h0000_1234);
    expect_rsp(1'b1, 32'h0, 1'b0);
    respond(32'h5555_5555, 2);
    issue(1'b1, 32'h0000_0100, 32'hCAFE_1234, F3_B, 1'b1, BHW_BYTE, 32'h0000_0034);
    expect_rsp(1'b1, 32'h0, 1'b0);
    respond(32'h5555_5555, 1);

    // Simultaneous fetch and load: data side wins, fetch follows
    @(posedge clk); #1;
    i_ls_req = 1'b1; i_ls_addr = 32'h200; i_ls_funct3 = F3_W; i_ls_write = 1'b0;
    i_if_req = 1'b1; i_if_addr = 32'h40;
    @(negedge clk);
    chk("arb_ls_ready", 32'(o_ls_ready), 32'd1);
    chk("arb_if_ready", 32'(o_if_ready), 32'd0);
    @(posedge clk); #1 i_ls_req = 1'b0;
    @(negedge clk);
    chk("arb_bus_dv", 32'(o_bus_DV), 32'd1);
    chk("arb_bus_addr", o_bus_address, 32'h200);
    chk("arb_if_ready_busy", 32'(o_if_ready), 32'd0);
    expect_rsp(1'b1, 32'h1122_3344, 1'b0);
    respond(32'h1122_3344, 2);
    @(negedge clk);
    chk("arb_if_ready_next", 32'(o_if_ready), 32'd1);
    @(posedge clk); #1 i_if_req = 1'b0;
    @(negedge clk);
    chk("arb_if_bus_dv", 32'(o_bus_DV), 32'd1);
    chk("arb_if_bus_addr", o_bus_address, 32'h40);
    expect_rsp(1'b0, 32'h0BAD_F00D, 1'b0);
    respond(32'h0BAD_F00D, 1);

    // Timeout: no answer, then a late response that must be ignored
    issue(1'b1, 32'h0000_0400, 32'h0, F3_W, 1'b0, BHW_WORD, 32'h0);
    expect_rsp(1'b1, 32'h0, 1'b1);
    cyc = 0;
    while (!o_ls_valid && cyc < 3 * TO) begin
      @(negedge clk);
      cyc++;
    end
    chk("to_valid", 32'(o_ls_valid), 32'd1);
    chk("to_error", 32'(o_ls_error), 32'd1);
    chk("to_latency_in_range", 32'(cyc >= TO && cyc <= TO + 3), 32'd1);
    @(posedge clk); #1 i_bus_DV = 1'b1; i_bus_data = 32'h7777_7777;
    @(posedge clk); #1 i_bus_DV = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("late_dv_ignored", 32'(o_ls_valid | o_if_valid | o_busy), 32'd0);
    end

    // Reset while waiting abandons the transaction
    issue(1'b1, 32'h0000_0300, 32'h0, F3_W, 1'b0, BHW_WORD, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1 i_rst = 1'b1;
    @(posedge clk); #1 i_rst = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_in_wait");
    @(posedge clk); #1 i_bus_DV = 1'b1; i_bus_data = 32'h1234_5678;
    @(posedge clk); #1 i_bus_DV = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_dv_ignored", 32'(o_ls_valid | o_if_valid | o_busy), 32'd0);
    end

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
- CPU-side master of the byte-serial memory bus. It turns instruction-fetch and load/store requests into single bus transactions.
- It drives address, data, size (bhw) and direction with a one-cycle request strobe, then waits for the memory subsystem's one-cycle data-valid pulse.
- It returns load data to the requester sign- or zero-extended.
- It sits between the core pipeline (fetch stage, LSU) and the memory top; it is the only initiator on that bus.

Parameters:
- TIMEOUT_CYCLES, 4096: cycles in WAIT without a response before the transaction is aborted with an error.
- TO_W, 13: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_if_req  in  1  fetch request; held until accepted
- i_if_addr  in  32  fetch address
- o_if_ready  out  1  fetch accepted this cycle when i_if_req=1
- o_if_data  out  32  fetched word
- o_if_valid  out  1  one-cycle pulse: o_if_data valid
- i_ls_req  in  1  load/store request; held until accepted
- i_ls_addr  in  32  data address
- i_ls_wdata  in  32  store data (low bytes significant)
- i_ls_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_ls_write  in  1  1=store, 0=load
- o_ls_ready  out  1  data request accepted this cycle
- o_ls_data  out  32  extended load result (0 for stores)
- o_ls_valid  out  1  one-cycle completion pulse (loads and stores)
- o_ls_error  out  1  with o_ls_valid/o_if_valid: transaction timed out
- o_bus_data  out  32  write data to memory
- o_bus_address  out  32  byte address
- o_bus_DV  out  1  one-cycle request strobe
- o_bhw  out  3  001 byte, 010 half, 100 word
- o_write_notread  out  1  1=write
- i_bus_data  in  32  read data; byte k at [8k+7:8k], little-endian from the address
- i_bus_DV  in  1  one-cycle response pulse
- o_busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0. A reset mid-WAIT abandons the transaction. Any later i_bus_DV seen in IDLE is ignored.
- FSM states:
  - IDLE: accept a request and go to ISSUE.
  - ISSUE: o_bus_DV=1 for exactly this cycle; go to WAIT.
  - WAIT: count cycles. On i_bus_DV go to RESP. On count == TIMEOUT_CYCLES go to RESP with the error flag set.
  - RESP: drive the selected valid for exactly one cycle; go to IDLE.
- Arbitration, IDLE only, combinational:
  - o_ls_ready = IDLE & i_ls_req.
  - o_if_ready = IDLE & i_if_req & ~i_ls_req (data has priority).
  - Ready signals are 0 in all other states. Accepted fields are latched on acceptance.
- Bus fields (registered, stable from ISSUE until leaving WAIT):
  - Address = latched address, no alignment check; the memory side is byte-serial.
  - Fetch: bhw=100, write=0.
  - LS: funct3[1:0] 00→001, 01→010, 10→100. Code 11 is treated as word.
  - Store data masked to size: byte → {24'b0, wdata[7:0]}; half → {16'b0, wdata[15:0]}; word → wdata. Loads drive 0.
- Load extension (unsigned when funct3[2]=1):
  - Byte uses i_bus_data[7:0]; half uses [15:0]; word uses all 32 bits.
  - Upper response bytes beyond the size are don't-care and must be ignored.
- Response data is registered on i_bus_DV. Latency: acceptance cycle N → o_bus_DV at N+1; i_bus_DV at M → valid at M+1.
- i_bus_DV in ISSUE (same cycle as the strobe) is impossible and ignored. i_bus_DV in IDLE/RESP is ignored.
- Timeout: the valid of the owning port pulses together with o_ls_error; data = 0.
- Back-to-back: a new request may be accepted in the IDLE cycle right after RESP (minimum 4 cycles per transaction).

Decomposition:
- Shared package mem_bus_pkg:
  - BHW_BYTE/BHW_HALF/BHW_WORD constants.
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - FSM state encoding.
  - Owner encoding (OWN_IF/OWN_LS).
- One combinational sub-module load_extend: inputs funct3 and raw word, output extended word. Reused by core writeback.

Test Plan:
- Fetch 0x00000010, memory answers 0xDEADBEEF after 5 cycles → o_bus_DV one cycle with addr 0x10, bhw 100, write 0; o_if_valid=1 and o_if_data=0xDEADBEEF one cycle after i_bus_DV.
- LB at 0x00000003, bus returns 0x12345680 → o_ls_data 0xFFFFFF80, bhw 001. LBU, same return → 0x00000080.
- LH at 0x00000102, bus returns 0xAAAA8001 → 0xFFFF8001. LHU, same return → 0x00008001. Upper bytes ignored.
- SH addr 0x100, wdata 0xCAFE1234 → o_bus_data 0x00001234, bhw 010, write 1; o_ls_valid, o_ls_data 0 on response. SB, same wdata → o_bus_data 0x00000034.
- Fetch and load asserted in the same IDLE cycle → o_ls_ready=1, o_if_ready=0; load completes; fetch accepted in the next IDLE cycle.
- Timeout and reset:
  - No response for TIMEOUT_CYCLES → o_ls_valid and o_ls_error pulse together, data 0; a late i_bus_DV is ignored, with no spurious valid.
  - i_rst in WAIT → all outputs 0 next cycle, state IDLE.
